// File: rtl/mem_lsu_pkg.sv
// Shared encodings, FSM states and defaults for the load/store unit.
package mem_lsu_pkg;

    localparam int unsigned RAM_WORDS_DEF = 65536;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE_WR
    } state_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        return ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane selection for loads (extract + extend) and sub-word store merge.
module lsu_lane_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_ram_q,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;

    always_comb begin
        w_bsh   = {i_lane, 3'b000};
        w_hsh   = {i_lane[1], 4'b0000};
        w_byte  = i_ram_q[w_bsh +: 8];
        w_half  = i_ram_q[w_hsh +: 16];
        o_load  = i_ram_q;
        o_merge = i_ram_q;
        unique case (i_size)
            SZ_BYTE: begin
                o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merge[w_bsh +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merge[w_hsh +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load  = i_ram_q;
                o_merge = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-addressed RAM; sub-word stores
// are done as read-modify-write because the RAM only writes whole words.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned RAM_WORDS = RAM_WORDS_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_A,
    output logic [31:0] ram_D,
    output logic        ram_WE,
    input  logic [31:0] ram_Q
);

    localparam logic [32:0] ADDR_LIMIT = 33'(RAM_WORDS) * 33'd4;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    state_t      w_next;
    logic        w_err;
    logic        w_accept;
    logic        w_acc_err;
    logic        w_done;
    logic        w_wr;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    lsu_lane_align u_align (
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_lane     (r_addr[1:0]),
        .i_ram_q    (ram_Q),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    assign w_err = (req_size == 2'd3) ||
                   is_misaligned(req_size, req_addr[1:0]) ||
                   ({1'b0, req_addr} >= ADDR_LIMIT);

    assign req_ready  = (r_state == IDLE);
    assign ram_WE     = w_wr & ~RST;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_acc_err = 1'b0;
        w_done    = 1'b0;
        w_wr      = 1'b0;
        ram_A     = 32'h0;
        ram_D     = 32'h0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_err) w_acc_err = 1'b1;
                    else       w_next    = ACCESS;
                end
            end
            ACCESS: begin
                ram_A = {r_addr[31:2], 2'b00};
                if (r_we && (r_size != SZ_WORD)) begin
                    w_next = MERGE_WR;
                end else begin
                    w_next = IDLE;
                    w_done = 1'b1;
                    if (r_we) begin
                        w_wr  = 1'b1;
                        ram_D = r_wdata;
                    end
                end
            end
            MERGE_WR: begin
                ram_A  = {r_addr[31:2], 2'b00};
                ram_D  = r_merge;
                w_wr   = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_uns        <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_merge      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= w_done | w_acc_err;
            r_resp_err   <= w_acc_err;
            r_resp_rdata <= (w_done && !r_we) ? w_load : 32'h0;
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == ACCESS) r_merge <= w_merge;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural word RAM.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int unsigned RW = 65536;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_A;
    logic [31:0] ram_D;
    logic        ram_WE;
    logic [31:0] ram_Q;

    logic [31:0] mem [RW];
    logic        bd_we = 1'b0;
    logic [15:0] bd_idx = 16'h0;
    logic [31:0] bd_data = 32'h0;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    logic [31:0] we_a = 32'h0;
    logic [31:0] we_d = 32'h0;
    int acc_cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    mem_lsu #(.RAM_WORDS(RW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_A        (ram_A),
        .ram_D        (ram_D),
        .ram_WE       (ram_WE),
        .ram_Q        (ram_Q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (ram_WE) mem[ram_A[17:2]] <= ram_D;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    assign ram_Q = mem[ram_A[17:2]];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] idx, input logic [31:0] d);
        @(posedge CLK); #1;
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(posedge CLK); #1;
        bd_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er,
                         input logic ee, input int lat, input bit track);
        int t;
        t = 0;
        do begin
            @(posedge CLK); #1;
            t++;
        end while (!req_ready && t < 20);
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL issue_wait: req_ready stuck low for addr %h", a);
        end
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        acc_cyc = cyc + 1;
        if (track) sb.push_back('{er, ee, cyc + lat});
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d responses missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0;
        int sh_acc;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge CLK);
                    if (ram_WE) begin
                        we_cnt++;
                        we_cyc = cyc;
                        we_a = ram_A;
                        we_d = ram_D;
                    end
                    if (resp_valid) begin
                        if (sb.size() == 0) begin
                            check("spurious_resp", {31'h0, resp_valid}, 32'h0);
                        end else begin
                            e = sb.pop_front();
                            check("resp_rdata", resp_rdata, e.rdata);
                            check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                            check("resp_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        join_none

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_ram_we", {31'h0, ram_WE}, 32'h0);
        check("rst_ram_a", ram_A, 32'h0);
        check("rst_ram_d", ram_D, 32'h0);
        RST = 1'b0;

        preload(16'h0040, 32'h8899AABB);
        preload(16'h0080, 32'h00000000);
        preload(16'hFFFF, 32'h01234567);

        issue(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 32'h000000AA, 1'b0, 2, 1);
        issue(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2, 1);
        issue(1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 2, 1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2, 1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h3FFFC, 32'h0, 32'h01234567, 1'b0, 2, 1);
        drain();

        w0 = we_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h12345677, 32'h0, 1'b0, 3, 1);
        drain();
        check("sb_we_count", we_cnt - w0, 32'd1);
        check("sb_we_cycle", we_cyc, acc_cyc + 1);
        check("sb_ram_a", we_a, 32'h100);
        check("sb_ram_d", we_d, 32'h7799AABB);
        check("sb_mem", mem[16'h0040], 32'h7799AABB);

        preload(16'h0040, 32'h8899AABB);
        issue(1'b1, SZ_HALF, 1'b0, 32'h100, 32'h0000CAFE, 32'h0, 1'b0, 3, 1);
        sh_acc = acc_cyc;
        issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h8899CAFE, 1'b0, 2, 1);
        check("b2b_accept_cycle", acc_cyc, sh_acc + 3);
        drain();

        w0 = we_cnt;
        issue(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1);
        issue(1'b1, SZ_HALF, 1'b0, 32'h101, 32'hFFFF, 32'h0, 1'b1, 1, 1);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h40000, 32'h0, 32'h0, 1'b1, 1, 1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h40000, 32'h5A5A5A5A, 32'h0, 1'b1, 1, 1);
        drain();
        check("err_we_count", we_cnt - w0, 32'd0);
        check("err_mem", mem[16'h0040], 32'h8899CAFE);

        w0 = we_cnt;
        issue(1'b1, SZ_WORD, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        drain();
        check("sw_we_count", we_cnt - w0, 32'd1);
        check("sw_we_cycle", we_cyc, acc_cyc);
        check("sw_ram_a", we_a, 32'h200);
        check("sw_ram_d", we_d, 32'hDEADBEEF);
        check("sw_mem", mem[16'h0080], 32'hDEADBEEF);

        w0 = we_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'h00000055, 32'h0, 1'b0, 3, 0);
        @(posedge CLK); #1;
        check("rst_mid_ready_low", {31'h0, req_ready}, 32'h0);
        RST = 1'b1;
        #1;
        check("rst_mid_we_gated", {31'h0, ram_WE}, 32'h0);
        @(posedge CLK); #1;
        check("rst_mid_idle", {31'h0, req_ready}, 32'h1);
        check("rst_mid_no_resp", {31'h0, resp_valid}, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("rst_rel_ready", {31'h0, req_ready}, 32'h1);
        check("rst_we_count", we_cnt - w0, 32'd0);
        check("rst_mem", mem[16'h0040], 32'h8899CAFE);

        issue(1'b0, SZ_BYTE, 1'b0, 32'h100, 32'h0, 32'hFFFFFFFE, 1'b0, 2, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
